// File: rtl/icache_refill_if.sv
// Signal bundle between the refill engine, the icache controller/L1 arrays and the memory read port.
// The slave modport is the refill engine's view; master is the icache/memory side.
interface icache_refill_if;
    logic         irq;
    logic [31:0]  if_addr;
    logic         ext_busy;
    logic         L2_busy;
    logic         L2_rdy;
    logic         complete;
    logic [127:0] data_wd;
    logic         valid_wd;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_rdy;
    logic [31:0]  mem_rd;

    modport master (
        output irq, if_addr, ext_busy, mem_rdy, mem_rd,
        input  L2_busy, L2_rdy, complete, data_wd, valid_wd, mem_req, mem_addr
    );

    modport slave (
        input  irq, if_addr, ext_busy, mem_rdy, mem_rd,
        output L2_busy, L2_rdy, complete, data_wd, valid_wd, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: fetches a 128-bit line as four 32-bit beats and
// runs the L2_busy / L2_rdy / complete handshake toward the icache controller.
//
// state | meaning
// IDLE  | waiting for irq with ext_busy low; line outputs held at 0
// FETCH | requesting beat 'beat' at line_addr + 4*beat until mem_rdy
// RDY   | line assembled, L2_rdy pulse, data_wd/valid_wd presented
// WRITE | L1 arrays capture data_wd/valid_wd
// DONE  | complete pulse, then back to IDLE
module icache_refill (
    input  logic           clk,
    input  logic           rst,
    icache_refill_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        RDY   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        beat;
    logic [31:0]       line_addr;
    logic [3:0][31:0]  line_buf;
    logic              accept;
    logic              hold_line;

    assign accept    = (state == IDLE) && bus.irq && !bus.ext_busy;
    assign hold_line = (state == RDY) || (state == WRITE) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.mem_req  = 1'b0;
        bus.mem_addr = 32'h0000_0000;
        bus.L2_rdy   = 1'b0;
        bus.complete = 1'b0;
        bus.data_wd  = 128'h0;
        bus.valid_wd = 1'b0;
        bus.L2_busy  = bus.ext_busy || (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = line_addr + {28'h000_0000, beat, 2'b00};
                if (bus.mem_rdy && (beat == 2'd3)) begin
                    state_nxt = RDY;
                end
            end
            RDY: begin
                bus.L2_rdy = 1'b1;
                state_nxt  = WRITE;
            end
            WRITE: begin
                state_nxt = DONE;
            end
            DONE: begin
                bus.complete = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (hold_line) begin
            bus.data_wd  = line_buf;
            bus.valid_wd = 1'b1;
        end
    end

    // Word k of the line lands in data_wd[32k+31:32k]; beat wraps to 0 after the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat      <= 2'd0;
            line_addr <= 32'h0000_0000;
            line_buf  <= '0;
        end else begin
            if (accept) begin
                line_addr <= bus.if_addr & 32'hFFFF_FFF0;
                beat      <= 2'd0;
            end else if ((state == FETCH) && bus.mem_rdy) begin
                line_buf[beat] <= bus.mem_rd;
                beat           <= beat + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed vector table, hand-written corner
// sequences and randomized refills checked against a line-level reference model.
module tb_icache_refill;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    icache_refill_if bus ();

    icache_refill dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       addr;
        logic [3:0][31:0]  d;
        logic [3:0][7:0]   w;
        bit                churn;
        bit                b2b;
        logic [31:0]       exp_base;
        logic [127:0]      exp_line;
        int                exp_rdy;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input string tag);
        cycle();
        bus.irq      = 1'b0;
        bus.ext_busy = 1'b0;
        bus.mem_rdy  = 1'($urandom_range(0, 1));
        bus.mem_rd   = $urandom;
        #1;
        chk({tag, " idle mem_req"},  128'(bus.mem_req),  128'd0);
        chk({tag, " idle L2_rdy"},   128'(bus.L2_rdy),   128'd0);
        chk({tag, " idle complete"}, 128'(bus.complete), 128'd0);
        chk({tag, " idle data_wd"},  bus.data_wd,        128'd0);
        chk({tag, " idle valid_wd"}, 128'(bus.valid_wd), 128'd0);
        chk({tag, " idle L2_busy"},  128'(bus.L2_busy),  128'd0);
    endtask

    // Reference: after acceptance the engine asks for words base+4k in order, each held
    // until its data arrives; the line is those words concatenated (word0 lowest), then
    // one L2_rdy cycle, one write cycle and one complete cycle.
    task automatic run_refill(input string tag, input logic [31:0] addr,
                              input logic [3:0][31:0] d, input logic [3:0][7:0] w,
                              input bit churn, input logic [31:0] exp_base,
                              input logic [127:0] exp_line, input int exp_rdy);
        int          mb;
        int          wc;
        bit          exp_req;
        logic [31:0] exp_addr;
        mb = 0;
        wc = 0;
        cycle();
        bus.irq      = 1'b1;
        bus.if_addr  = addr;
        bus.ext_busy = 1'b0;
        bus.mem_rdy  = 1'($urandom_range(0, 1));
        bus.mem_rd   = $urandom;
        #1;
        chk({tag, " accept L2_busy"},  128'(bus.L2_busy),  128'd0);
        chk({tag, " accept mem_req"},  128'(bus.mem_req),  128'd0);
        chk({tag, " accept data_wd"},  bus.data_wd,        128'd0);
        chk({tag, " accept valid_wd"}, 128'(bus.valid_wd), 128'd0);
        for (int c = 1; c <= exp_rdy + 2; c++) begin
            cycle();
            exp_req  = (mb < 4);
            exp_addr = exp_base + 32'(4 * mb);
            bus.irq      = churn ? 1'b0 : (c < exp_rdy);
            bus.if_addr  = churn ? 32'hFFFF_FFF0 : addr;
            bus.ext_busy = 1'($urandom_range(0, 1));
            if (mb < 4) begin
                if (wc < int'(w[mb])) begin
                    bus.mem_rdy = 1'b0;
                    bus.mem_rd  = $urandom;
                    wc++;
                end else begin
                    bus.mem_rdy = 1'b1;
                    bus.mem_rd  = d[mb];
                    mb++;
                    wc = 0;
                end
            end else begin
                bus.mem_rdy = 1'($urandom_range(0, 1));
                bus.mem_rd  = $urandom;
            end
            #1;
            chk($sformatf("%s c%0d mem_req", tag, c), 128'(bus.mem_req), 128'(exp_req));
            if (exp_req)
                chk($sformatf("%s c%0d mem_addr", tag, c), 128'(bus.mem_addr), 128'(exp_addr));
            chk($sformatf("%s c%0d L2_rdy", tag, c), 128'(bus.L2_rdy), 128'(c == exp_rdy));
            chk($sformatf("%s c%0d complete", tag, c), 128'(bus.complete), 128'(c == exp_rdy + 2));
            chk($sformatf("%s c%0d L2_busy", tag, c), 128'(bus.L2_busy), 128'd1);
            if (c >= exp_rdy) begin
                chk($sformatf("%s c%0d data_wd", tag, c), bus.data_wd, exp_line);
                chk($sformatf("%s c%0d valid_wd", tag, c), 128'(bus.valid_wd), 128'd1);
            end
        end
    endtask

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]      ra;
        logic [3:0][31:0] rd;
        logic [3:0][7:0]  rw;
        int               sum;

        checks = 0;
        errors = 0;

        vecs[0] = '{addr: 32'h0000_1238, d: {32'h44, 32'h33, 32'h22, 32'h11}, w: {8'd0, 8'd0, 8'd0, 8'd0},
                    churn: 1'b0, b2b: 1'b0, exp_base: 32'h0000_1230,
                    exp_line: 128'h00000044_00000033_00000022_00000011, exp_rdy: 5};
        vecs[1] = '{addr: 32'h0000_1238, d: {32'h44, 32'h33, 32'h22, 32'h11}, w: {8'd2, 8'd2, 8'd2, 8'd2},
                    churn: 1'b0, b2b: 1'b0, exp_base: 32'h0000_1230,
                    exp_line: 128'h00000044_00000033_00000022_00000011, exp_rdy: 13};
        vecs[2] = '{addr: 32'h0000_1238, d: {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001},
                    w: {8'd0, 8'd0, 8'd1, 8'd0}, churn: 1'b1, b2b: 1'b0, exp_base: 32'h0000_1230,
                    exp_line: 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, exp_rdy: 6};
        vecs[3] = '{addr: 32'h0000_100C, d: {32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 32'h0D0D_0D0D},
                    w: {8'd1, 8'd0, 8'd0, 8'd0}, churn: 1'b0, b2b: 1'b0, exp_base: 32'h0000_1000,
                    exp_line: 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D, exp_rdy: 6};
        vecs[4] = '{addr: 32'h0000_2000, d: {32'h8000_0003, 32'h8000_0002, 32'h8000_0001, 32'h8000_0000},
                    w: {8'd0, 8'd0, 8'd0, 8'd0}, churn: 1'b0, b2b: 1'b1, exp_base: 32'h0000_2000,
                    exp_line: 128'h80000003_80000002_80000001_80000000, exp_rdy: 5};

        rst          = 1'b1;
        bus.irq      = 1'b0;
        bus.if_addr  = 32'h0;
        bus.ext_busy = 1'b0;
        bus.mem_rdy  = 1'b0;
        bus.mem_rd   = 32'h0;

        cycle();
        bus.irq = 1'b1;
        #1;
        chk("rst mem_req",  128'(bus.mem_req),  128'd0);
        chk("rst mem_addr", 128'(bus.mem_addr), 128'd0);
        chk("rst L2_rdy",   128'(bus.L2_rdy),   128'd0);
        chk("rst complete", 128'(bus.complete), 128'd0);
        chk("rst data_wd",  bus.data_wd,        128'd0);
        chk("rst valid_wd", 128'(bus.valid_wd), 128'd0);
        chk("rst L2_busy0", 128'(bus.L2_busy),  128'd0);
        cycle();
        bus.ext_busy = 1'b1;
        #1;
        chk("rst L2_busy1", 128'(bus.L2_busy),  128'd1);
        chk("rst hold mem_req", 128'(bus.mem_req), 128'd0);
        cycle();
        rst          = 1'b0;
        bus.irq      = 1'b0;
        bus.ext_busy = 1'b0;

        for (int i = 0; i < 5; i++) begin
            if (!vecs[i].b2b) idle_cycle($sformatf("v%0d", i));
            run_refill($sformatf("v%0d", i), vecs[i].addr, vecs[i].d, vecs[i].w, vecs[i].churn,
                       vecs[i].exp_base, vecs[i].exp_line, vecs[i].exp_rdy);
        end

        // Blocked start: irq held while the dcache path owns L2.
        idle_cycle("blk");
        for (int k = 0; k < 3; k++) begin
            cycle();
            bus.irq      = 1'b1;
            bus.if_addr  = 32'h0000_1238;
            bus.ext_busy = 1'b1;
            bus.mem_rdy  = 1'b1;
            #1;
            chk($sformatf("blk%0d mem_req", k), 128'(bus.mem_req), 128'd0);
            chk($sformatf("blk%0d L2_busy", k), 128'(bus.L2_busy), 128'd1);
        end
        run_refill("blk", 32'h0000_1238, {32'h44, 32'h33, 32'h22, 32'h11}, '0, 1'b0,
                   32'h0000_1230, 128'h00000044_00000033_00000022_00000011, 5);

        // Reset after beat 2 has been captured.
        idle_cycle("rmo");
        cycle();
        bus.irq     = 1'b1;
        bus.if_addr = 32'h0000_5554;
        bus.mem_rdy = 1'b0;
        #1;
        for (int b = 0; b < 3; b++) begin
            cycle();
            bus.mem_rdy = 1'b1;
            bus.mem_rd  = 32'hEE00_0000 + 32'(b);
            #1;
            chk($sformatf("rmo b%0d mem_addr", b), 128'(bus.mem_addr), 128'(32'h0000_5550 + 32'(4 * b)));
        end
        cycle();
        rst         = 1'b1;
        bus.mem_rd  = 32'hEE00_0003;
        #1;
        cycle();
        rst         = 1'b0;
        bus.irq     = 1'b0;
        bus.mem_rdy = 1'b0;
        #1;
        chk("rmo mem_req",  128'(bus.mem_req),  128'd0);
        chk("rmo mem_addr", 128'(bus.mem_addr), 128'd0);
        chk("rmo data_wd",  bus.data_wd,        128'd0);
        chk("rmo valid_wd", 128'(bus.valid_wd), 128'd0);
        chk("rmo L2_busy",  128'(bus.L2_busy),  128'd0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            #1;
            chk($sformatf("rmo quiet%0d L2_rdy", k),   128'(bus.L2_rdy),   128'd0);
            chk($sformatf("rmo quiet%0d complete", k), 128'(bus.complete), 128'd0);
        end
        run_refill("rmo2", 32'h0000_5554, {32'h1111_0004, 32'h1111_0003, 32'h1111_0002, 32'h1111_0001},
                   {8'd1, 8'd0, 8'd0, 8'd1}, 1'b0, 32'h0000_5550,
                   128'h11110004_11110003_11110002_11110001, 7);

        for (int r = 0; r < 20; r++) begin
            ra  = $urandom;
            sum = 0;
            for (int k = 0; k < 4; k++) begin
                rd[k] = $urandom;
                rw[k] = 8'($urandom_range(0, 3));
                sum  += int'(rw[k]);
            end
            if ($urandom_range(0, 1) == 0) idle_cycle($sformatf("r%0d", r));
            run_refill($sformatf("r%0d", r), ra, rd, rw, 1'($urandom_range(0, 1)),
                       ra & 32'hFFFF_FFF0, {rd[3], rd[2], rd[1], rd[0]}, 5 + sum);
        end
        idle_cycle("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
